// File: rtl/latch_bank_write_ctrl.sv
// Round-robin write sequencer for a bank of level-sensitive latch words.
// Drives a shared data bus with setup/enable/hold phasing around a one-hot enable.
module latch_bank_write_ctrl #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int EN_CYC    = 1,
    parameter int HOLD_CYC  = 1,
    localparam int AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*AW-1:0]    req_addr,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       done,
    output logic                   err,
    output logic                   busy,
    output logic [WIDTH-1:0]       lat_d,
    output logic [DEPTH-1:0]       lat_en
);

    localparam int RW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int MAXC = (SETUP_CYC > EN_CYC) ?
                          ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                          ((EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC);
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0]    SETUP_LD = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0]    EN_LD    = CW'(EN_CYC - 1);
    localparam logic [CW-1:0]    HOLD_LD  = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [RW-1:0]    RR_ONE   = RW'(1);
    localparam logic [RW-1:0]    RR_LAST  = RW'(N_REQ - 1);
    localparam logic [RW:0]      N_W      = (RW + 1)'(N_REQ);
    localparam logic [AW:0]      DEPTH_W  = (AW + 1)'(DEPTH);
    localparam logic [N_REQ-1:0] GNT_ONE  = N_REQ'(1);
    localparam logic [DEPTH-1:0] EN_ONE   = DEPTH'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ENABLE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [RW-1:0]     rr_q, rr_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [N_REQ-1:0]  gnt_q, gnt_d;
    logic [N_REQ-1:0]  done_q, done_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic [WIDTH-1:0]  lat_d_q, lat_d_d;
    logic [DEPTH-1:0]  lat_en_q, lat_en_d;

    logic [AW-1:0]     addr_a [N_REQ];
    logic [WIDTH-1:0]  data_a [N_REQ];
    logic [RW:0]       arb_sum_s;
    logic [RW-1:0]     arb_idx_s;
    logic [RW-1:0]     win_s;
    logic              win_vld_s;
    logic              last_hold_s;
    logic              in_range_s;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign addr_a[i] = req_addr[i*AW +: AW];
        assign data_a[i] = req_data[i*WIDTH +: WIDTH];
    end

    // Round-robin pick: scan downward so the requester closest to rr_q wins last.
    always_comb begin
        win_s     = '0;
        win_vld_s = 1'b0;
        arb_sum_s = '0;
        arb_idx_s = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            arb_sum_s = {1'b0, rr_q} + (RW + 1)'(k);
            arb_idx_s = (arb_sum_s >= N_W) ? RW'(arb_sum_s - N_W) : RW'(arb_sum_s);
            win_s     = req[arb_idx_s] ? arb_idx_s : win_s;
            win_vld_s = win_vld_s | req[arb_idx_s];
        end
    end

    // Phase sequencing and next values of every registered output.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        addr_d  = addr_q;
        data_d  = data_q;
        gnt_d   = gnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld_s) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                    gnt_d   = GNT_ONE << win_s;
                    addr_d  = addr_a[win_s];
                    data_d  = data_a[win_s];
                    rr_d    = (win_s == RR_LAST) ? '0 : (win_s + RR_ONE);
                end else begin
                    gnt_d   = '0;
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_ENABLE;
                    cnt_d   = EN_LD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            S_ENABLE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                gnt_d   = '0;
            end
        endcase

        // Outputs are derived from the next state so they line up with it after the edge.
        in_range_s  = ({1'b0, addr_d} < DEPTH_W);
        last_hold_s = (state_d == S_HOLD) && (cnt_d == '0);
        done_d      = last_hold_s ? gnt_d : '0;
        err_d       = last_hold_s && !in_range_s;
        busy_d      = (state_d != S_IDLE);
        lat_d_d     = busy_d ? data_d : '0;
        lat_en_d    = ((state_d == S_ENABLE) && in_range_s) ? (EN_ONE << addr_d) : '0;
    end

    // State, captured transaction and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rr_q     <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            lat_d_q  <= '0;
            lat_en_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_q     <= rr_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            lat_d_q  <= lat_d_d;
            lat_en_q <= lat_en_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign err    = err_q;
    assign busy   = busy_q;
    assign lat_d  = lat_d_q;
    assign lat_en = lat_en_q;

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Scoreboard bench for latch_bank_write_ctrl: default instance plus a DEPTH=3,
// 2/3/2-phased instance for phasing and out-of-range behaviour.
module tb_latch_bank_write_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst_b;
    logic [3:0]  req, req_b;
    logic [7:0]  req_addr, req_addr_b;
    logic [31:0] req_data, req_data_b;
    logic [3:0]  gnt, done, lat_en;
    logic        err, busy;
    logic [7:0]  lat_d;
    logic [3:0]  gnt_b, done_b;
    logic        err_b, busy_b;
    logic [7:0]  lat_d_b;
    logic [2:0]  lat_en_b;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] data;
        logic [3:0] en;
        logic       err;
    } txn_t;

    typedef struct packed {
        logic [3:0] gnt;
        logic [3:0] done;
        logic       err;
        logic       busy;
        logic [7:0] lat_d;
        logic [2:0] en;
    } cyc_t;

    txn_t sb_q[$];
    cyc_t cyc_q[$];

    latch_bank_write_ctrl u_dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
        .gnt(gnt), .done(done), .err(err), .busy(busy), .lat_d(lat_d), .lat_en(lat_en)
    );

    latch_bank_write_ctrl #(
        .N_REQ(4), .WIDTH(8), .DEPTH(3), .SETUP_CYC(2), .EN_CYC(3), .HOLD_CYC(2)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .req_addr(req_addr_b), .req_data(req_data_b),
        .gnt(gnt_b), .done(done_b), .err(err_b), .busy(busy_b), .lat_d(lat_d_b), .lat_en(lat_en_b)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (done == 4'd0 && n < 40);
        check_val(tag, 64'(done != 4'd0), 64'd1);
    endtask

    task automatic push_txn(input logic [3:0] g, input logic [7:0] d, input logic [3:0] e);
        txn_t t;
        t.gnt  = g;
        t.data = d;
        t.en   = e;
        t.err  = 1'b0;
        sb_q.push_back(t);
    endtask

    // Pushes the expected 8-cycle profile of a 2/3/2 transaction, then compares it cycle by cycle.
    task automatic run_b(input logic [3:0] g, input logic [7:0] d, input logic [2:0] e, input logic er);
        cyc_t c;
        for (int k = 1; k <= 8; k++) begin
            c.gnt   = (k <= 7) ? g : 4'd0;
            c.busy  = (k <= 7);
            c.lat_d = (k <= 7) ? d : 8'd0;
            c.en    = (k >= 3 && k <= 5) ? e : 3'd0;
            c.done  = (k == 7) ? g : 4'd0;
            c.err   = (k == 7) ? er : 1'b0;
            cyc_q.push_back(c);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) req_b = 4'd0;
            c = cyc_q.pop_front();
            check_val("b_gnt", 64'(gnt_b), 64'(c.gnt));
            check_val("b_busy", 64'(busy_b), 64'(c.busy));
            check_val("b_lat_d", 64'(lat_d_b), 64'(c.lat_d));
            check_val("b_lat_en", 64'(lat_en_b), 64'(c.en));
            check_val("b_done", 64'(done_b), 64'(c.done));
            check_val("b_err", 64'(err_b), 64'(c.err));
        end
    endtask

    logic [3:0] en_seen;
    logic [3:0] en_acc_v;
    txn_t       mon_t;

    // Transaction monitor for the default instance: invariants every cycle, scoreboard on done.
    always @(negedge clk) begin
        if (rst) begin
            en_seen <= 4'd0;
        end else begin
            check_val("en_onehot0", 64'($onehot0(lat_en)), 64'd1);
            check_val("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
            en_acc_v = en_seen | lat_en;
            if (done != 4'd0) begin
                if (sb_q.size() == 0) begin
                    check_val("unexpected_done", 64'(done), 64'd0);
                end else begin
                    mon_t = sb_q.pop_front();
                    check_val("sb_gnt", 64'(gnt), 64'(mon_t.gnt));
                    check_val("sb_done", 64'(done), 64'(mon_t.gnt));
                    check_val("sb_lat_d", 64'(lat_d), 64'(mon_t.data));
                    check_val("sb_lat_en", 64'(en_acc_v), 64'(mon_t.en));
                    check_val("sb_err", 64'(err), 64'(mon_t.err));
                end
                en_seen <= 4'd0;
            end else begin
                en_seen <= en_acc_v;
            end
        end
    end

    initial begin
        rst        = 1'b1;
        rst_b      = 1'b1;
        req        = 4'b1111;
        req_addr   = {2'd3, 2'd2, 2'd1, 2'd0};
        req_data   = {8'h13, 8'h12, 8'h11, 8'h10};
        req_b      = 4'd0;
        req_addr_b = 8'd0;
        req_data_b = 32'd0;
        tick();
        tick();
        check_val("rst_gnt", 64'(gnt), 64'd0);
        check_val("rst_done", 64'(done), 64'd0);
        check_val("rst_err", 64'(err), 64'd0);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_lat_d", 64'(lat_d), 64'd0);
        check_val("rst_lat_en", 64'(lat_en), 64'd0);

        // Round-robin with all requesters held: 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            push_txn(4'd1 << (k % 4), 8'h10 + 8'(k % 4), 4'd1 << (k % 4));
        end
        rst = 1'b0;
        tick();
        check_val("release_gnt", 64'(gnt), 64'b0001);
        for (int k = 0; k < 5; k++) wait_done("rr_done");
        req = 4'd0;
        tick();
        tick();
        check_val("rr_idle_busy", 64'(busy), 64'd0);

        // Single write, requester 2 to word 3
        req            = 4'b0100;
        req_addr[5:4]  = 2'd3;
        req_data[23:16] = 8'hA5;
        push_txn(4'b0100, 8'hA5, 4'b1000);
        tick();
        check_val("sw_c1_gnt", 64'(gnt), 64'b0100);
        check_val("sw_c1_lat_d", 64'(lat_d), 64'hA5);
        check_val("sw_c1_lat_en", 64'(lat_en), 64'd0);
        check_val("sw_c1_busy", 64'(busy), 64'd1);
        req = 4'd0;
        tick();
        check_val("sw_c2_lat_en", 64'(lat_en), 64'b1000);
        tick();
        check_val("sw_c3_done", 64'(done), 64'b0100);
        check_val("sw_c3_lat_en", 64'(lat_en), 64'd0);
        tick();
        check_val("sw_c4_busy", 64'(busy), 64'd0);
        check_val("sw_c4_gnt", 64'(gnt), 64'd0);
        check_val("sw_c4_lat_d", 64'(lat_d), 64'd0);

        // Request churn after grant must not disturb the transaction
        req            = 4'b0010;
        req_addr[3:2]  = 2'd2;
        req_data[15:8] = 8'h3C;
        push_txn(4'b0010, 8'h3C, 4'b0100);
        tick();
        check_val("churn_gnt", 64'(gnt), 64'b0010);
        req            = 4'd0;
        req_data[15:8] = 8'hFF;
        req_addr[3:2]  = 2'd0;
        tick();
        check_val("churn_lat_d", 64'(lat_d), 64'h3C);
        check_val("churn_lat_en", 64'(lat_en), 64'b0100);
        tick();
        check_val("churn_done", 64'(done), 64'b0010);
        tick();

        // Winner keeps req high and drops to lowest priority (pointer at 2)
        req = 4'b0011;
        push_txn(4'b0001, 8'h10, 4'b0001);
        push_txn(4'b0010, 8'hFF, 4'b0001);
        push_txn(4'b0001, 8'h10, 4'b0001);
        for (int k = 0; k < 3; k++) wait_done("keep_done");
        req = 4'd0;
        tick();
        tick();

        // Reset during ENABLE aborts without done
        req             = 4'b1000;
        req_addr[7:6]   = 2'd1;
        req_data[31:24] = 8'h77;
        tick();
        check_val("abort_gnt", 64'(gnt), 64'b1000);
        req = 4'd0;
        tick();
        check_val("abort_en", 64'(lat_en), 64'b0010);
        rst = 1'b1;
        tick();
        check_val("abort_lat_en", 64'(lat_en), 64'd0);
        check_val("abort_gnt_clr", 64'(gnt), 64'd0);
        check_val("abort_busy", 64'(busy), 64'd0);
        check_val("abort_lat_d", 64'(lat_d), 64'd0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("abort_no_done", 64'(done), 64'd0);
        end

        // Pointer returns to 0 after reset
        req = 4'b1111;
        push_txn(4'b0001, 8'h10, 4'b0001);
        tick();
        check_val("abort_rr_reset", 64'(gnt), 64'b0001);
        req = 4'd0;
        wait_done("post_abort_done");
        tick();
        tick();

        // Second instance: 2/3/2 phasing, then out-of-range address on DEPTH=3
        rst_b = 1'b0;
        tick();
        tick();
        req_b            = 4'b0001;
        req_addr_b[1:0]  = 2'd2;
        req_data_b[7:0]  = 8'h5A;
        run_b(4'b0001, 8'h5A, 3'b100, 1'b0);
        tick();
        req_b            = 4'b0010;
        req_addr_b[3:2]  = 2'd3;
        req_data_b[15:8] = 8'hC3;
        run_b(4'b0010, 8'hC3, 3'b000, 1'b1);

        check_val("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
